adt7420_responder: RTL and testbench

- I2C target (responder) that emulates the ADT7420 temperature sensor register interface on a two-wire bus.
- It is the other end of the on-board temperature-sensor I2C master. It serves as the closed-loop simulation model for that master.
- It can also be synthesised so an external I2C master can read the board's temperature.
- All logic runs in the 100 MHz domain. SCL and SDA are oversampled, and SDA is driven open-drain through an output-enable.

---
 rtl/adt7420_responder_pkg.sv | 45 ++++
 rtl/i2c_bus_sampler.sv | 63 ++++++
 rtl/adt7420_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_adt7420_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adt7420_responder_pkg.sv
// Shared types and constants for the ADT7420 register-interface I2C responder:
// FSM state encoding, register map addresses and the read-data mux.
package adt7420_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_TX        = 4'd7,
        ST_TX_ACK    = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4B;
    localparam logic [7:0] DEFAULT_ID_VALUE = 8'hCB;

    function automatic logic [7:0] read_map(
        input logic [7:0]  ptr,
        input logic [15:0] shadow,
        input logic [7:0]  cfg,
        input logic [7:0]  id
    );
        logic [7:0] val;
        case (ptr)
            REG_TEMP_MSB: val = shadow[15:8];
            REG_TEMP_LSB: val = shadow[7:0];
            REG_STATUS:   val = 8'h00;
            REG_CONFIG:   val = cfg;
            REG_ID:       val = id;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises raw SCL/SDA and produces registered SCL edge and START/STOP
// pulses plus an SDA level aligned with them (SYNC_STAGES+1 cycles latency).
module i2c_bus_sampler #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_s_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_now;
    logic                   sda_now;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   sda_s_q;

    assign scl_now = scl_sync_q[SYNC_STAGES-1];
    assign sda_now = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chains, edge-detect register and registered event pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_s_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_now;
            sda_prev_q <= sda_now;
            scl_rise_q <= scl_now & ~scl_prev_q;
            scl_fall_q <= ~scl_now & scl_prev_q;
            start_q    <= scl_now & scl_prev_q & ~sda_now & sda_prev_q;
            stop_q     <= scl_now & scl_prev_q & sda_now & ~sda_prev_q;
            sda_s_q    <= sda_now;
        end
    end

    assign scl_rise_o  = scl_rise_q;
    assign scl_fall_o  = scl_fall_q;
    assign start_det_o = start_q;
    assign stop_det_o  = stop_q;
    assign sda_s_o     = sda_s_q;

endmodule

// File: rtl/adt7420_responder.sv
// I2C target emulating the ADT7420 register interface (pointer, temp, status,
// config, ID). Optional SCL-low bus-hang recovery: ADT7420_RESPONDER_TIMEOUT_EN.
module adt7420_responder
    import adt7420_responder_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter logic [7:0]  ID_VALUE    = DEFAULT_ID_VALUE,
    parameter int unsigned SYNC_STAGES = 2
`ifdef ADT7420_RESPONDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
`endif
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_word,
    output logic [7:0]  config_reg,
    output logic        addressed,
    output logic [7:0]  reg_ptr
);

    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        sda_s;
    logic        timeout_hit;

    state_e      state_q,     state_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        rw_q,        rw_d;
    logic        sda_oe_q,    sda_oe_d;
    logic        addressed_q, addressed_d;
    logic [7:0]  config_q,    config_d;
    logic [7:0]  reg_ptr_q,   reg_ptr_d;
    logic [15:0] shadow_q,    shadow_d;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;

    i2c_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i       (CLK100MHZ),
        .rst_i       (rst),
        .scl_i       (scl_in),
        .sda_i       (sda_in),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .sda_s_o     (sda_s)
    );

`ifdef ADT7420_RESPONDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            scl_high_q;

    // SCL level tracker and SCL-low counter for bus-hang recovery
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            scl_high_q <= 1'b1;
            to_cnt_q   <= '0;
        end else begin
            if (scl_rise) begin
                scl_high_q <= 1'b1;
            end else if (scl_fall) begin
                scl_high_q <= 1'b0;
            end else begin
                scl_high_q <= scl_high_q;
            end
            if (scl_rise || scl_fall || scl_high_q || timeout_hit ||
                state_q == ST_IDLE || state_q == ST_IGNORE) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign timeout_hit = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            addressed_q <= 1'b0;
            config_q    <= 8'h00;
            reg_ptr_q   <= 8'h00;
            shadow_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            addressed_q <= addressed_d;
            config_q    <= config_d;
            reg_ptr_q   <= reg_ptr_d;
            shadow_q    <= shadow_d;
        end
    end

    // Next-state logic: bus events first, then per-state byte handling
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        config_d    = config_q;
        reg_ptr_d   = reg_ptr_q;
        shadow_d    = shadow_q;
        rx_byte     = {shift_q[6:0], sda_s};
        tx_byte     = 8'h00;

        if (stop_det) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else if (timeout_hit) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                ST_ADDR: begin
                                    rw_d    = sda_s;
                                    state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                                end
                                ST_PTR: begin
                                    reg_ptr_d = rx_byte;
                                    state_d   = ST_PTR_ACK;
                                end
                                default: begin
                                    config_d  = (reg_ptr_q == REG_CONFIG) ? rx_byte : config_q;
                                    reg_ptr_d = reg_ptr_q + 8'd1;
                                    state_d   = ST_WDATA_ACK;
                                end
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // sda_oe_q is the ACK phase: first fall pulls low, second fall ends the slot
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = addressed_q | (state_q == ST_ADDR_ACK);
                        end else if (state_q == ST_ADDR_ACK && rw_q) begin
                            shadow_d  = temp_word;
                            tx_byte   = read_map(reg_ptr_q, temp_word, config_q, ID_VALUE);
                            sda_oe_d  = ~tx_byte[7];
                            shift_d   = {tx_byte[6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                            state_d   = ST_TX;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            reg_ptr_d = reg_ptr_q + 8'd1;
                            shift_d   = read_map(reg_ptr_q + 8'd1, shadow_q, config_q, ID_VALUE);
                            bit_cnt_d = 4'd0;
                            state_d   = ST_TX;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe     = sda_oe_q;
    assign config_reg = config_q;
    assign addressed  = addressed_q;
    assign reg_ptr    = reg_ptr_q;

endmodule

// File: tb/tb_adt7420_responder.sv
// Self-checking bench for adt7420_responder: bit-banged I2C master, register
// model of the ADT7420 map, directed scenarios then randomized transactions.
module tb_adt7420_responder;

    localparam int Q = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] temp_word = 16'h0000;
    logic        sda_oe;
    logic        addressed;
    logic [7:0]  config_reg;
    logic [7:0]  reg_ptr;
    logic        sda_bus;

    int vectors = 0;
    int errors  = 0;
    int oe_cnt  = 0;

    logic [7:0] m_ptr = 8'h00;
    logic [7:0] m_cfg = 8'h00;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

`ifdef ADT7420_RESPONDER_TIMEOUT_EN
    adt7420_responder #(.TIMEOUT_CYCLES(1000)) dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .temp_word  (temp_word),
        .config_reg (config_reg),
        .addressed  (addressed),
        .reg_ptr    (reg_ptr)
    );
`else
    adt7420_responder #(.SYNC_STAGES(2)) dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .temp_word  (temp_word),
        .config_reg (config_reg),
        .addressed  (addressed),
        .reg_ptr    (reg_ptr)
    );
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_reg(input logic [7:0] ptr, input logic [15:0] shadow);
        if (ptr == 8'h00)      return shadow[15:8];
        else if (ptr == 8'h01) return shadow[7:0];
        else if (ptr == 8'h03) return m_cfg;
        else if (ptr == 8'h0B) return 8'hCB;
        else                   return 8'h00;
    endfunction

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1; tick(Q);
            scl_m = 1'b0; tick(2);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q/2);
        ack = sda_bus; tick(Q/2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_m = 1'b1; tick(Q/2);
            b[i] = sda_bus; tick(Q/2);
            scl_m = 1'b0;
        end
        tick(2);
        sda_m = nack; tick(Q);
        scl_m = 1'b1; tick(Q);
        scl_m = 1'b0; tick(2);
        sda_m = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] ptr, input int n, input logic [7:0] d0, input logic [7:0] d1);
        logic       ack;
        logic [7:0] d;
        bus_start();
        send_byte(8'h96, ack);
        check("wr_addr_ack", 16'(ack), 16'h0000);
        check("wr_addressed", 16'(addressed), 16'h0001);
        send_byte(ptr, ack);
        check("wr_ptr_ack", 16'(ack), 16'h0000);
        m_ptr = ptr;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : d1;
            send_byte(d, ack);
            check("wr_data_ack", 16'(ack), 16'h0000);
            if (m_ptr == 8'h03) m_cfg = d;
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check("wr_addressed_after_stop", 16'(addressed), 16'h0000);
        check("wr_config_reg", 16'(config_reg), 16'(m_cfg));
        check("wr_reg_ptr", 16'(reg_ptr), 16'(m_ptr));
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n,
                           input logic chg, input logic [15:0] new_temp);
        logic        ack;
        logic [15:0] shadow;
        logic [7:0]  b;
        bus_start();
        if (set_ptr) begin
            send_byte(8'h96, ack);
            check("rd_waddr_ack", 16'(ack), 16'h0000);
            send_byte(ptr, ack);
            check("rd_ptr_ack", 16'(ack), 16'h0000);
            m_ptr = ptr;
            bus_start();
        end
        send_byte(8'h97, ack);
        check("rd_raddr_ack", 16'(ack), 16'h0000);
        shadow = temp_word;
        for (int k = 0; k < n; k++) begin
            if (k == 0 && chg) temp_word = new_temp;
            recv_byte(k == n - 1, b);
            check("rd_byte", 16'(b), 16'(model_reg(m_ptr, shadow)));
            if (k != n - 1) m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check("rd_addressed_after_stop", 16'(addressed), 16'h0000);
        check("rd_reg_ptr", 16'(reg_ptr), 16'(m_ptr));
    endtask

    initial begin
        logic       ack;
        int         oe_before;
        logic [7:0] ptr_tab [7];
        logic [7:0] p;

        ptr_tab[0] = 8'h00; ptr_tab[1] = 8'h01; ptr_tab[2] = 8'h02; ptr_tab[3] = 8'h03;
        ptr_tab[4] = 8'h0B; ptr_tab[5] = 8'hFF; ptr_tab[6] = 8'h00;

        rst = 1'b1;
        tick(5);
        check("rst_sda_oe", 16'(sda_oe), 16'h0000);
        check("rst_config_reg", 16'(config_reg), 16'h0000);
        check("rst_addressed", 16'(addressed), 16'h0000);
        check("rst_reg_ptr", 16'(reg_ptr), 16'h0000);
        rst = 1'b0;
        tick(Q);

        // pointer write then read of the temperature pair
        temp_word = 16'h0C80;
        do_read(1'b1, 8'h00, 2, 1'b0, 16'h0000);

        // wrong address: never driven, never addressed
        oe_before = oe_cnt;
        bus_start();
        send_byte(8'h90, ack);
        check("badaddr_nack", 16'(ack), 16'h0001);
        send_byte(8'h00, ack);
        bus_stop();
        check("badaddr_no_drive", 16'(oe_cnt), 16'(oe_before));
        check("badaddr_addressed", 16'(addressed), 16'h0000);
        do_read(1'b1, 8'h01, 1, 1'b0, 16'h0000);

        // ID and config
        do_write(8'h03, 1, 8'hA0, 8'h00);
        check("cfg_A0", 16'(config_reg), 16'h00A0);
        do_read(1'b1, 8'h0B, 1, 1'b0, 16'h0000);

        // coherency of the MSB/LSB pair
        temp_word = 16'h0C80;
        do_read(1'b1, 8'h00, 2, 1'b1, 16'h0D00);
        do_read(1'b1, 8'h00, 2, 1'b0, 16'h0000);

        // pointer wrap and read from the persisted pointer
        do_write(8'hFF, 2, 8'h11, 8'h22);
        do_read(1'b0, 8'h00, 3, 1'b0, 16'h0000);

        // reset in the middle of a read while SDA is being pulled low
        do_write(8'h03, 1, 8'h5A, 8'h00);
        do_write(8'h00, 0, 8'h00, 8'h00);
        temp_word = 16'h0C80;
        bus_start();
        send_byte(8'h97, ack);
        check("rstmid_addr_ack", 16'(ack), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(Q); scl_m = 1'b1; tick(Q); scl_m = 1'b0;
        end
        tick(Q/2);
        check("rstmid_pre_oe", 16'(sda_oe), 16'h0001);
        rst = 1'b1;
        tick(1);
        check("rstmid_sda_oe", 16'(sda_oe), 16'h0000);
        check("rstmid_reg_ptr", 16'(reg_ptr), 16'h0000);
        check("rstmid_config", 16'(config_reg), 16'h0000);
        check("rstmid_addressed", 16'(addressed), 16'h0000);
        rst = 1'b0;
        m_ptr = 8'h00;
        m_cfg = 8'h00;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        do_read(1'b0, 8'h00, 2, 1'b0, 16'h0000);

`ifdef ADT7420_RESPONDER_TIMEOUT_EN
        // SCL held low after the address ACK
        bus_start();
        send_byte(8'h96, ack);
        check("to_addr_ack", 16'(ack), 16'h0000);
        tick(900);
        check("to_before_addressed", 16'(addressed), 16'h0001);
        tick(200);
        check("to_addressed", 16'(addressed), 16'h0000);
        check("to_sda_oe", 16'(sda_oe), 16'h0000);
        sda_m = 1'b1;
        scl_m = 1'b1; tick(Q);
        do_read(1'b1, 8'h0B, 1, 1'b0, 16'h0000);
`endif

        // randomized transactions against the register model
        for (int it = 0; it < 10; it++) begin
            temp_word = 16'($urandom);
            p = ptr_tab[$urandom_range(0, 6)];
            if (it % 7 == 6) p = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_write(p, int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
            end else begin
                do_read(1'($urandom_range(0, 1)), p, int'($urandom_range(1, 3)),
                        1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
